reg_writeback_queue: RTL and testbench

Write-side front end for the 32x32 register file. Accepts register write requests from the ALU result path and the load/memory return path, buffers them in order in a small FIFO, and drives the register file's single write port (address/data/enable) with one registered write per cycle. Also provides forwarding lookups so readers see writes still pending in the queue or on the write port.

---
 rtl/reg_writeback_queue.sv | 143 ++++++++++++++
 tb/tb_reg_writeback_queue.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback_queue.sv
// Register-file write front end: merges ALU and load-return writes into an
// in-order FIFO and drains one registered write per cycle to the write port.
// Optional forwarding lookups are compiled in when WBQ_BYPASS_EN is defined.
module reg_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alu_valid,
  output logic                         alu_ready,
  input  logic [ADDR_W-1:0]            alu_rd,
  input  logic [DATA_W-1:0]            alu_wd,
  input  logic                         mem_valid,
  output logic                         mem_ready,
  input  logic [ADDR_W-1:0]            mem_rd,
  input  logic [DATA_W-1:0]            mem_wd,
  output logic                         wb_we,
  output logic [ADDR_W-1:0]            wb_addr,
  output logic [DATA_W-1:0]            wb_data,
  input  logic [ADDR_W-1:0]            rs1_addr,
  input  logic [ADDR_W-1:0]            rs2_addr,
  output logic                         rs1_hit,
  output logic                         rs2_hit,
  output logic [DATA_W-1:0]            rs1_data,
  output logic [DATA_W-1:0]            rs2_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [ADDR_W-1:0] q_rd [DEPTH];
  logic [DATA_W-1:0] q_wd [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr, mem_slot;
  logic [CNT_W-1:0]  cnt, free;
  logic              alu_store, mem_store, pop;

  // Readiness is judged on occupancy at the start of the cycle; the pop that
  // happens on the same edge is deliberately not credited.
  assign free      = CNT_W'(DEPTH) - cnt;
  assign alu_ready = (free != '0);
  assign mem_ready = alu_valid ? (free >= CNT_W'(2)) : (free != '0);

  // Writes to x0 complete the handshake but are dropped here.
  assign alu_store = alu_valid && alu_ready && (alu_rd != '0);
  assign mem_store = mem_valid && mem_ready && (mem_rd != '0);
  assign pop       = (cnt != '0);
  assign mem_slot  = alu_store ? (wr_ptr + PTR_W'(1)) : wr_ptr;

  assign count = cnt;
  assign empty = (cnt == '0);
  assign full  = (cnt == CNT_W'(DEPTH));

  // Pointer and occupancy bookkeeping; ALU entry always lands before mem entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      rd_ptr <= rd_ptr + PTR_W'(pop);
      wr_ptr <= wr_ptr + PTR_W'(alu_store) + PTR_W'(mem_store);
      cnt    <= cnt + CNT_W'(alu_store) + CNT_W'(mem_store) - CNT_W'(pop);
    end
  end

  // Entry storage needs no reset: occupancy alone says which slots are live.
  always_ff @(posedge clk) begin
    if (alu_store) begin
      q_rd[wr_ptr] <= alu_rd;
      q_wd[wr_ptr] <= alu_wd;
    end
    if (mem_store) begin
      q_rd[mem_slot] <= mem_rd;
      q_wd[mem_slot] <= mem_wd;
    end
  end

  // Write port register: head entry moves out whenever the queue is occupied.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_we   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else if (pop) begin
      wb_we   <= 1'b1;
      wb_addr <= q_rd[rd_ptr];
      wb_data <= q_wd[rd_ptr];
    end else begin
      wb_we   <= 1'b0;
    end
  end

`ifdef WBQ_BYPASS_EN
  // Newest match wins: the write port is oldest, then FIFO entries oldest to
  // newest, each later match overriding the earlier one.
  function automatic void lookup(input  logic [ADDR_W-1:0] a,
                                 output logic              hit,
                                 output logic [DATA_W-1:0] d);
    logic [PTR_W-1:0] idx;
    hit = 1'b0;
    d   = '0;
    if (wb_we && (wb_addr == a)) begin
      hit = 1'b1;
      d   = wb_data;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < cnt) && (q_rd[idx] == a)) begin
        hit = 1'b1;
        d   = q_wd[idx];
      end
    end
    if (a == '0) begin
      hit = 1'b0;
      d   = '0;
    end
  endfunction

  // Combinational forwarding for both read ports.
  always_comb begin
    rs1_hit  = 1'b0;
    rs1_data = '0;
    rs2_hit  = 1'b0;
    rs2_data = '0;
    lookup(rs1_addr, rs1_hit, rs1_data);
    lookup(rs2_addr, rs2_hit, rs2_data);
  end
`else
  // Forwarding compiled out: lookup ports stay but never report a hit.
  logic unused_lookup;
  assign unused_lookup = ^{rs1_addr, rs2_addr};
  assign rs1_hit  = 1'b0;
  assign rs2_hit  = 1'b0;
  assign rs1_data = '0;
  assign rs2_data = '0;
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Bench for reg_writeback_queue: queue-based reference model checked every
// cycle on the falling edge, directed scenarios with literal expectations,
// then randomized traffic with occasional resets.
module tb_reg_writeback_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, mem_valid;
  logic        alu_ready, mem_ready;
  logic [4:0]  alu_rd, mem_rd, rs1_addr, rs2_addr, wb_addr;
  logic [31:0] alu_wd, mem_wd, wb_data, rs1_data, rs2_data;
  logic        wb_we, rs1_hit, rs2_hit, empty, full;
  logic [2:0]  count;

  reg_writeback_queue #(.DEPTH(DEPTH), .ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_wd(alu_wd),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_wd(mem_wd),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_hit(rs1_hit), .rs2_hit(rs2_hit), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  int nchecks = 0;
  int nfail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending writes as a plain in-order list plus the write port.
  logic [4:0]  mq_rd[$];
  logic [31:0] mq_wd[$];
  logic        m_we = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  logic        model_ok = 1'b0;
  logic        acc_a = 1'b0, acc_m = 1'b0;

  function automatic void fwd(input logic [4:0] a, output logic h, output logic [31:0] d);
    h = 1'b0;
    d = '0;
`ifdef WBQ_BYPASS_EN
    if (a != 0) begin
      for (int i = mq_rd.size() - 1; i >= 0; i--) begin
        if (!h && mq_rd[i] == a) begin
          h = 1'b1;
          d = mq_wd[i];
        end
      end
      if (!h && m_we && m_addr == a) begin
        h = 1'b1;
        d = m_data;
      end
    end
`endif
  endfunction

  // Compare every DUT output against the model mid-cycle, and decide handshakes.
  always @(negedge clk) begin
    if (model_ok) begin
      int   fr;
      logic e_ar, e_mr, h1, h2;
      logic [31:0] d1, d2;
      fr   = DEPTH - mq_rd.size();
      e_ar = (fr >= 1);
      e_mr = alu_valid ? (fr >= 2) : (fr >= 1);
      fwd(rs1_addr, h1, d1);
      fwd(rs2_addr, h2, d2);
      chk("alu_ready", alu_ready, e_ar);
      chk("mem_ready", mem_ready, e_mr);
      chk("count", count, mq_rd.size());
      chk("empty", empty, mq_rd.size() == 0);
      chk("full", full, mq_rd.size() == DEPTH);
      chk("wb_we", wb_we, m_we);
      chk("wb_addr", wb_addr, m_addr);
      chk("wb_data", wb_data, m_data);
      chk("rs1_hit", rs1_hit, h1);
      chk("rs1_data", rs1_data, d1);
      chk("rs2_hit", rs2_hit, h2);
      chk("rs2_data", rs2_data, d2);
      acc_a = alu_valid && e_ar;
      acc_m = mem_valid && e_mr;
    end
  end

  // Advance the model on each rising edge.
  always @(posedge clk) begin
    if (rst) begin
      mq_rd.delete();
      mq_wd.delete();
      m_we = 1'b0; m_addr = '0; m_data = '0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      if (mq_rd.size() > 0) begin
        m_we = 1'b1;
        m_addr = mq_rd.pop_front();
        m_data = mq_wd.pop_front();
      end else begin
        m_we = 1'b0;
      end
      if (acc_a && alu_rd != 0) begin mq_rd.push_back(alu_rd); mq_wd.push_back(alu_wd); end
      if (acc_m && mem_rd != 0) begin mq_rd.push_back(mem_rd); mq_wd.push_back(mem_wd); end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic v, input logic [4:0] rd, input logic [31:0] wd);
    alu_valid = v; alu_rd = rd; alu_wd = wd;
  endtask

  task automatic set_mem(input logic v, input logic [4:0] rd, input logic [31:0] wd);
    mem_valid = v; mem_rd = rd; mem_wd = wd;
  endtask

  initial begin
    rst = 1'b1;
    set_alu(1'b0, 5'd0, 32'd0);
    set_mem(1'b0, 5'd0, 32'd0);
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    step(); step();
    chk("rst_alu_ready", alu_ready, 1'b1);
    chk("rst_mem_ready", mem_ready, 1'b1);
    chk("rst_count", count, 3'd0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_wb_we", wb_we, 1'b0);
    chk("rst_wb_addr", wb_addr, 5'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_rs1_hit", rs1_hit, 1'b0);
    rst = 1'b0;

    // Single write: visible on the port one edge after acceptance, for one cycle.
    set_alu(1'b1, 5'd5, 32'h5);
    step();
    set_alu(1'b0, 5'd0, 32'd0);
    chk("t1_count_1", count, 3'd1);
    chk("t1_we_early", wb_we, 1'b0);
    step();
    chk("t1_we", wb_we, 1'b1);
    chk("t1_addr", wb_addr, 5'd5);
    chk("t1_data", wb_data, 32'h5);
    chk("t1_count_0", count, 3'd0);
    step();
    chk("t1_we_off", wb_we, 1'b0);

    // Dual accept: ALU entry drains first.
    set_alu(1'b1, 5'd6, 32'h4);
    set_mem(1'b1, 5'd7, 32'h9);
    step();
    set_alu(1'b0, 5'd0, 32'd0);
    set_mem(1'b0, 5'd0, 32'd0);
    chk("t2_count_2", count, 3'd2);
    step();
    chk("t2_first", {wb_we, wb_addr, wb_data}, {1'b1, 5'd6, 32'h4});
    step();
    chk("t2_second", {wb_we, wb_addr, wb_data}, {1'b1, 5'd7, 32'h9});
    chk("t2_count_0", count, 3'd0);

    // Back-to-back dual requests: with a pop every occupied cycle DEPTH=4
    // tops out at DEPTH-1, where the load port must be refused.
    set_alu(1'b1, 5'd10, 32'hA0);
    set_mem(1'b1, 5'd11, 32'hB0);
    step();
    set_alu(1'b1, 5'd12, 32'hA1);
    set_mem(1'b1, 5'd13, 32'hB1);
    step();
    chk("t3_count", count, 3'd3);
    chk("t3_mem_blocked", mem_ready, 1'b0);
    chk("t3_alu_ready", alu_ready, 1'b1);
    chk("t3_full", full, 1'b0);
    alu_valid = 1'b0;
    #1;
    chk("t3_mem_alone", mem_ready, 1'b1);
    set_mem(1'b0, 5'd0, 32'd0);
    repeat (5) step();
    chk("t3_drained", empty, 1'b1);

    // x0 writes vanish.
    step();
    set_alu(1'b1, 5'd0, 32'hFFFF_FFFF);
    step();
    set_alu(1'b0, 5'd0, 32'd0);
    chk("t4_count", count, 3'd0);
    step();
    chk("t4_no_we", wb_we, 1'b0);
    rs1_addr = 5'd0;
    #1;
    chk("t4_rs0", rs1_hit, 1'b0);

    // Forwarding priority: queue newest over queue older over write port.
    set_alu(1'b1, 5'd3, 32'h10);
    set_mem(1'b1, 5'd3, 32'h11);
    step();
    set_alu(1'b1, 5'd3, 32'h22);
    set_mem(1'b0, 5'd0, 32'd0);
    step();
    set_alu(1'b1, 5'd8, 32'h33);
    set_mem(1'b1, 5'd9, 32'h44);
    rs1_addr = 5'd3;
    rs2_addr = 5'd5;
    #1;
`ifdef WBQ_BYPASS_EN
    chk("t5_hit", rs1_hit, 1'b1);
    chk("t5_data", rs1_data, 32'h22);
`else
    chk("t5_hit", rs1_hit, 1'b0);
    chk("t5_data", rs1_data, 32'h0);
`endif
    chk("t5_miss", rs2_hit, 1'b0);

    // Reset with three pending entries and an active write port.
    step();
    chk("t6_count3", count, 3'd3);
    chk("t6_we", wb_we, 1'b1);
    rst = 1'b1;
    set_alu(1'b0, 5'd0, 32'd0);
    set_mem(1'b0, 5'd0, 32'd0);
    step();
    rst = 1'b0;
    chk("t6_count0", count, 3'd0);
    chk("t6_port", {wb_we, wb_addr, wb_data}, 38'd0);
    chk("t6_rs1", rs1_hit, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t6_no_stale", wb_we, 1'b0);
    end

    // Randomized traffic; unaccepted requests are held stable.
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(0, 60) == 0);
      if (rst || !(alu_valid && !acc_a))
        set_alu($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom);
      if (rst || !(mem_valid && !acc_m))
        set_mem($urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom);
      rs1_addr = 5'($urandom_range(0, 7));
      rs2_addr = 5'($urandom_range(0, 7));
      step();
    end
    rst = 1'b0;
    set_alu(1'b0, 5'd0, 32'd0);
    set_mem(1'b0, 5'd0, 32'd0);
    repeat (6) step();
    chk("final_empty", empty, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end
endmodule
